// File: rtl/wb_pkg.sv
// Shared types and sizing helpers for the Wishbone command sequencer.
package wb_pkg;

  localparam int unsigned CMD_ADDR_W = 32;
  localparam int unsigned CMD_DATA_W = 32;
  localparam int unsigned SEL_W      = CMD_DATA_W / 8;

  typedef enum logic [1:0] {
    StIdle,
    StBus,
    StResp
  } wb_state_e;

  typedef struct packed {
    logic                  we;
    logic [CMD_ADDR_W-1:0] adr;
    logic [CMD_DATA_W-1:0] dat;
    logic [SEL_W-1:0]      sel;
  } cmd_t;

  // Wait counter width; a zero timeout still needs a 1-bit counter to exist.
  function automatic int unsigned cnt_w(int unsigned timeout);
    return (timeout == 0) ? 1 : $clog2(timeout + 1);
  endfunction

endpackage

// File: rtl/wb_cmd_fifo.sv
// Command FIFO; pointers carry an extra wrap bit to tell full from empty.
module wb_cmd_fifo import wb_pkg::*; #(
  parameter int unsigned Depth = 4
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic push_i,
  input  cmd_t data_i,
  input  logic pop_i,
  output cmd_t data_o,
  output logic full_o,
  output logic empty_o
);

  localparam int unsigned AW = $clog2(Depth);

  cmd_t          mem_q [Depth];
  logic [AW:0]   wptr_q, rptr_q;
  logic          do_push, do_pop;

  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      if (do_push) wptr_q <= wptr_q + (AW + 1)'(1);
      if (do_pop)  rptr_q <= rptr_q + (AW + 1)'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wptr_q[AW-1:0]] <= data_i;
  end

  assign empty_o = (wptr_q == rptr_q);
  assign full_o  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign data_o  = mem_q[rptr_q[AW-1:0]];

endmodule

// File: rtl/wb_master_seq.sv
// Wishbone classic initiator: runs queued commands one at a time and returns
// read data / timeout status on a valid/ready response port.
module wb_master_seq import wb_pkg::*; #(
  parameter int unsigned ADDR_W    = CMD_ADDR_W,
  parameter int unsigned DATA_W    = CMD_DATA_W,
  parameter int unsigned CMD_DEPTH = 4,
  parameter int unsigned TIMEOUT   = 255
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_ni,
  input  logic              cmd_valid_i,
  output logic              cmd_ready_o,
  input  logic              cmd_we_i,
  input  logic [ADDR_W-1:0] cmd_adr_i,
  input  logic [DATA_W-1:0] cmd_dat_i,
  input  logic [DATA_W/8-1:0] cmd_sel_i,
  output logic              wbm_cyc_o,
  output logic              wbm_stb_o,
  output logic              wbm_we_o,
  output logic [DATA_W/8-1:0] wbm_sel_o,
  output logic [ADDR_W-1:0] wbm_adr_o,
  output logic [DATA_W-1:0] wbm_dat_o,
  input  logic [DATA_W-1:0] wbm_dat_i,
  input  logic              wbm_ack_i,
  output logic              rsp_valid_o,
  input  logic              rsp_ready_i,
  output logic [DATA_W-1:0] rsp_dat_o,
  output logic              rsp_timeout_o,
  output logic              busy_o
);

  localparam int unsigned CntW = cnt_w(TIMEOUT);

  cmd_t      push_cmd, head_cmd;
  logic      fifo_full, fifo_empty, pop;
  wb_state_e state_q, state_d;
  logic      cyc_q, cyc_d, we_q, we_d, rsp_valid_q, rsp_valid_d, rsp_to_q, rsp_to_d;
  logic [DATA_W/8-1:0] sel_q, sel_d;
  logic [ADDR_W-1:0]   adr_q, adr_d;
  logic [DATA_W-1:0]   dat_q, dat_d, rsp_dat_q, rsp_dat_d;
  logic [CntW-1:0]     cnt_q, cnt_d;

  assign push_cmd    = '{we: cmd_we_i, adr: cmd_adr_i, dat: cmd_dat_i, sel: cmd_sel_i};
  // Held low while in reset so nothing is offered into a FIFO being cleared.
  assign cmd_ready_o = wb_rst_ni && !fifo_full;

  wb_cmd_fifo #(
    .Depth (CMD_DEPTH)
  ) u_fifo (
    .clk_i   (wb_clk_i),
    .rst_ni  (wb_rst_ni),
    .push_i  (cmd_valid_i && cmd_ready_o),
    .data_i  (push_cmd),
    .pop_i   (pop),
    .data_o  (head_cmd),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  always_comb begin
    state_d     = state_q;
    pop         = 1'b0;
    cyc_d       = cyc_q;
    we_d        = we_q;
    sel_d       = sel_q;
    adr_d       = adr_q;
    dat_d       = dat_q;
    cnt_d       = cnt_q;
    rsp_valid_d = rsp_valid_q;
    rsp_dat_d   = rsp_dat_q;
    rsp_to_d    = rsp_to_q;
    case (state_q)
      StIdle: begin
        if (!fifo_empty) begin
          pop     = 1'b1;
          cyc_d   = 1'b1;
          we_d    = head_cmd.we;
          sel_d   = head_cmd.sel;
          adr_d   = head_cmd.adr;
          dat_d   = head_cmd.dat;
          cnt_d   = '0;
          state_d = StBus;
        end
      end
      StBus: begin
        // Ack takes priority over an expiring timeout in the same cycle.
        if (wbm_ack_i) begin
          cyc_d       = 1'b0;
          rsp_dat_d   = we_q ? '0 : wbm_dat_i;
          rsp_to_d    = 1'b0;
          rsp_valid_d = 1'b1;
          state_d     = StResp;
        end else if (TIMEOUT != 0 && cnt_q == CntW'(TIMEOUT - 1)) begin
          cyc_d       = 1'b0;
          rsp_dat_d   = '0;
          rsp_to_d    = 1'b1;
          rsp_valid_d = 1'b1;
          state_d     = StResp;
        end else if (cnt_q != '1) begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StResp: begin
        if (rsp_ready_i) begin
          rsp_valid_d = 1'b0;
          state_d     = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      state_q     <= StIdle;
      cyc_q       <= 1'b0;
      we_q        <= 1'b0;
      sel_q       <= '0;
      adr_q       <= '0;
      dat_q       <= '0;
      cnt_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_dat_q   <= '0;
      rsp_to_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      cyc_q       <= cyc_d;
      we_q        <= we_d;
      sel_q       <= sel_d;
      adr_q       <= adr_d;
      dat_q       <= dat_d;
      cnt_q       <= cnt_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_dat_q   <= rsp_dat_d;
      rsp_to_q    <= rsp_to_d;
    end
  end

  assign wbm_cyc_o     = cyc_q;
  assign wbm_stb_o     = cyc_q;
  assign wbm_we_o      = we_q;
  assign wbm_sel_o     = sel_q;
  assign wbm_adr_o     = adr_q;
  assign wbm_dat_o     = dat_q;
  assign rsp_valid_o   = rsp_valid_q;
  assign rsp_dat_o     = rsp_dat_q;
  assign rsp_timeout_o = rsp_to_q;
  assign busy_o        = (state_q != StIdle) || !fifo_empty;

endmodule

// File: tb/tb_wb_master_seq.sv
// Scoreboard bench for wb_master_seq: randomized commands against a slave
// model with planned ack delays; responses checked in push order.
module tb_wb_master_seq;

  localparam int TO = 8;

  typedef struct {
    logic        we;
    logic [31:0] adr;
    logic [31:0] dat;
    logic [3:0]  sel;
    int          delay;   // stb cycle carrying ack (1-based); > TO means never
    logic [31:0] rdata;
  } plan_t;

  typedef struct {
    logic [31:0] dat;
    logic        to;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        cmd_valid = 1'b0, cmd_ready, cmd_we = 1'b0;
  logic [31:0] cmd_adr = '0, cmd_dat = '0;
  logic [3:0]  cmd_sel = '0;
  logic        cyc, stb, we;
  logic [3:0]  sel;
  logic [31:0] adr, dat_o, dat_i = '0;
  logic        ack = 1'b0;
  logic        rsp_valid, rsp_ready = 1'b0, rsp_to, busy;
  logic [31:0] rsp_dat;

  int    n_cmp = 0, n_bad = 0;
  int    rsp_mode = 2;       // 0 hold low, 1 random, 2 always ready
  bit    force_ack = 1'b0;
  plan_t plan_q[$];
  exp_t  exp_q[$];

  wb_master_seq #(
    .ADDR_W(32), .DATA_W(32), .CMD_DEPTH(4), .TIMEOUT(TO)
  ) dut (
    .wb_clk_i(clk), .wb_rst_ni(rst_n),
    .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready), .cmd_we_i(cmd_we),
    .cmd_adr_i(cmd_adr), .cmd_dat_i(cmd_dat), .cmd_sel_i(cmd_sel),
    .wbm_cyc_o(cyc), .wbm_stb_o(stb), .wbm_we_o(we), .wbm_sel_o(sel),
    .wbm_adr_o(adr), .wbm_dat_o(dat_o), .wbm_dat_i(dat_i), .wbm_ack_i(ack),
    .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_dat_o(rsp_dat),
    .rsp_timeout_o(rsp_to), .busy_o(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Slave: counts stb cycles of the current transaction and acks on the planned one.
  initial begin
    int    k = 0;
    plan_t cur;
    cur = '{we: 1'b0, adr: '0, dat: '0, sel: '0, delay: 1, rdata: '0};
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        k = 0; ack = 1'b0;
      end else if (cyc && stb) begin
        if (k == 0) begin
          if (plan_q.size() == 0) begin
            n_cmp++; n_bad++;
            $display("FAIL unexpected_txn: got adr %0h expected no transaction", adr);
            cur.delay = 1;
          end else begin
            cur = plan_q.pop_front();
            chk("bus_we",  {63'd0, we}, {63'd0, cur.we});
            chk("bus_adr", {32'd0, adr}, {32'd0, cur.adr});
            chk("bus_dat", {32'd0, dat_o}, {32'd0, cur.dat});
            chk("bus_sel", {60'd0, sel}, {60'd0, cur.sel});
          end
        end
        k++;
        ack   = (k == cur.delay);
        dat_i = ack ? cur.rdata : $urandom;
      end else begin
        if (k != 0) chk("cyc_len", 64'(k), 64'((cur.delay < TO) ? cur.delay : TO));
        k = 0;
        ack   = force_ack || ($urandom_range(0, 3) == 0);  // stray acks must be ignored
        dat_i = $urandom;
      end
    end
  end

  // Response ready driven away from both sampling edges.
  initial forever begin
    @(posedge clk); #2;
    rsp_ready = (rsp_mode == 2) || (rsp_mode == 1 && $urandom_range(0, 1) == 1);
  end

  // Response monitor.
  initial forever begin
    exp_t e;
    @(negedge clk);
    if (rst_n && rsp_valid) begin
      if (exp_q.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL spurious_rsp: got rsp_valid 1 expected 0");
        @(negedge clk);
      end else if (rsp_ready) begin
        e = exp_q.pop_front();
        chk("rsp_dat",     {32'd0, rsp_dat}, {32'd0, e.dat});
        chk("rsp_timeout", {63'd0, rsp_to},  {63'd0, e.to});
      end
    end
  end

  // Called at a negedge; the handshake happens on the following posedge.
  task automatic send(input logic w, input logic [31:0] a, input logic [31:0] d,
                      input logic [3:0] s, input int dly);
    int    n = 0;
    plan_t p;
    exp_t  e;
    cmd_valid = 1'b1; cmd_we = w; cmd_adr = a; cmd_dat = d; cmd_sel = s;
    while (!cmd_ready && n < 500) begin @(negedge clk); n++; end
    if (!cmd_ready) begin
      n_cmp++; n_bad++;
      $display("FAIL cmd_accept: got ready 0 expected 1 within 500 cycles");
    end else begin
      p = '{we: w, adr: a, dat: d, sel: s, delay: dly, rdata: $urandom};
      e.to  = (dly > TO);
      e.dat = (w || e.to) ? 32'd0 : p.rdata;
      plan_q.push_back(p);
      exp_q.push_back(e);
    end
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while ((exp_q.size() != 0 || busy) && n < 3000) begin @(negedge clk); n++; end
    chk("drain_done", {63'd0, busy || exp_q.size() != 0}, 64'd0);
  endtask

  initial begin
    #1 rst_n = 1'b0;
    #2;
    chk("rst_cmd_ready", {63'd0, cmd_ready}, 64'd0);
    chk("rst_cyc",       {63'd0, cyc}, 64'd0);
    chk("rst_rsp_valid", {63'd0, rsp_valid}, 64'd0);
    chk("rst_busy",      {63'd0, busy}, 64'd0);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rel_cmd_ready", {63'd0, cmd_ready}, 64'd1);
    chk("rel_busy",      {63'd0, busy}, 64'd0);

    // Directed: single-cycle write, read with wait states, timeout, collision.
    send(1'b1, 32'h3000_0004, 32'h0000_00A5, 4'hF, 1);
    drain();
    send(1'b0, 32'h3000_0000, 32'h0, 4'hF, 4);
    plan_q[0].rdata = 32'hDEAD_BEEF;
    exp_q[0].dat    = 32'hDEAD_BEEF;
    drain();
    send(1'b0, 32'h3000_0008, 32'h0, 4'hF, 100);
    send(1'b1, 32'h3000_000C, 32'h1234_5678, 4'h3, 2);
    drain();
    send(1'b0, 32'h3000_0010, 32'h0, 4'hF, TO);
    drain();

    // Backpressure: responses held, five accepted, sixth refused while full.
    rsp_mode = 0;
    for (int i = 0; i < 5; i++) send(1'b0, 32'h4000_0000 + 32'(i * 4), 32'h0, 4'hF, 1 + i % 3);
    repeat (6) @(negedge clk);
    cmd_valid = 1'b1; cmd_adr = 32'h4000_0014;
    repeat (4) begin
      chk("full_ready", {63'd0, cmd_ready}, 64'd0);
      @(negedge clk);
    end
    cmd_valid = 1'b0;
    chk("full_busy", {63'd0, busy}, 64'd1);
    rsp_mode = 2;
    drain();

    // Reset during a read wait state.
    send(1'b0, 32'h5000_0000, 32'h0, 4'hF, 100);
    repeat (3) @(negedge clk);
    chk("pre_rst_cyc", {63'd0, cyc}, 64'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_cyc",       {63'd0, cyc || stb}, 64'd0);
    chk("mid_rst_rsp_valid", {63'd0, rsp_valid}, 64'd0);
    chk("mid_rst_ready",     {63'd0, cmd_ready}, 64'd0);
    chk("mid_rst_busy",      {63'd0, busy}, 64'd0);
    plan_q.delete();
    exp_q.delete();
    @(negedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    force_ack = 1'b1;
    repeat (4) begin
      @(negedge clk);
      chk("late_ack_cyc",   {63'd0, cyc}, 64'd0);
      chk("late_ack_busy",  {63'd0, busy}, 64'd0);
      chk("late_ack_ready", {63'd0, cmd_ready}, 64'd1);
    end
    force_ack = 1'b0;

    // Randomized traffic.
    for (int i = 0; i < 60; i++) begin
      if (i % 10 == 0) rsp_mode = $urandom_range(1, 2);
      send(1'($urandom_range(0, 1)), $urandom, $urandom, 4'($urandom),
           ($urandom_range(0, 7) == 0) ? 20 : $urandom_range(1, 10));
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
    rsp_mode = 2;
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no completion expected finish before 1ms");
    $fatal(1, "watchdog expired");
  end

endmodule
